mu0_mux_arb: RTL

- Parametrised, registered N-to-1 multiplexer for MU0 datapath/bus source selection; generalises the 12-bit 2-to-1 combinational mux.
- Runs in one of two modes:
  - Fixed-select mode, steered by Sel.
  - Round-robin arbitration mode, across requesting channels.
- Result is held in a one-deep output register with a valid/ready handshake, so downstream stalls back-pressure the sources.

---
 rtl/mu0_mux_arb.sv | 92 +++++++++
 1 files changed

// File: rtl/mu0_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : mu0_mux_arb
// Brief   : Registered N-to-1 source mux for the MU0 datapath with fixed-select
//           or round-robin arbitration and a valid/ready output stage.
// Revision: 1.0
// ============================================================================
module mu0_mux_arb #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Mode,
    input  logic [SELW-1:0]           Sel,
    input  logic [CHANNELS-1:0]       Req,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS-1:0]       Grant,
    output logic [WIDTH-1:0]          Q,
    input  logic                      Ready,
    output logic                      Valid,
    output logic [SELW-1:0]           Chan
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SELW-1:0]  chan_q;
    logic [SELW-1:0]  ptr;

    logic             load;
    logic             has_cand;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  idx;

    assign load = !valid_q || Ready;

    // Round-robin scans from ptr+1 downward in priority; iterating the offsets
    // in reverse lets the nearest requester overwrite any farther one.
    always_comb begin
        has_cand = 1'b0;
        cand     = '0;
        idx      = '0;
        if (!Mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (Sel == SELW'(i) && Req[i]) begin
                    has_cand = 1'b1;
                    cand     = SELW'(i);
                end
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                idx = SELW'((int'(ptr) + k) % CHANNELS);
                if (Req[idx]) begin
                    has_cand = 1'b1;
                    cand     = idx;
                end
            end
        end
    end

    always_comb begin
        Grant = '0;
        if (load && has_cand && !Reset) begin
            Grant = {{(CHANNELS-1){1'b0}}, 1'b1} << cand;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            ptr     <= SELW'(CHANNELS - 1);
        end else if (load) begin
            if (has_cand) begin
                data_q  <= D[int'(cand)*WIDTH +: WIDTH];
                chan_q  <= cand;
                valid_q <= 1'b1;
                ptr     <= cand;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Q     = data_q;
    assign Valid = valid_q;
    assign Chan  = chan_q;

endmodule
`default_nettype wire
